master_rx_port: RTL and testbench
=================================

# master_rx_port

Parametrised master-side serial receive port for the system bus read path. After a read instruction it handshakes each word of a burst with the slave, deserialises `rx_data` LSB- or MSB-first, and buffers received words in an internal first-word-fall-through FIFO. A downstream consumer (display/master-out logic) drains the FIFO with a valid/ready handshake. A stalled slave is abandoned after a programmable timeout.

## Interface
- `DATA_LEN`, 8, bits per word (≥2)
- `BURST_W`, 12, width of `burst_num`
- `FIFO_DEPTH`, 4, word buffer depth (power of 2, ≥2)
- `MSB_FIRST`, 0, 0: first serial bit → `data[0]`; 1: first serial bit → `data[DATA_LEN-1]`
- `TIMEOUT`, 255, max cycles waiting in HANDSHAKE per word; 0 disables the timeout

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low reset
- `tx_done` in 1: slave/bus transaction-start qualifier
- `instruction` in 2: operation code; 2'b11 = read
- `burst_num` in BURST_W: words in burst minus one
- `slave_valid` in 1: slave has a word ready to send
- `rx_data` in 1: serial data from slave
- `master_ready` out 1: port can accept the next word
- `out_valid` out 1: FIFO head valid
- `out_data` out DATA_LEN: FIFO head word
- `out_ready` in 1: consumer accepts head
- `fifo_count` out $clog2(FIFO_DEPTH)+1: words buffered
- `rx_done` out 1: one-cycle pulse, burst fully received
- `rx_timeout` out 1: one-cycle pulse, burst aborted

## Operation
- States: IDLE, HANDSHAKE, RECEIVE.
- IDLE: if `tx_done`=1 and `instruction`=2'b11, latch `burst_num` into words_left and go to HANDSHAKE; otherwise stay. `tx_done` is ignored outside IDLE.
- HANDSHAKE: `master_ready` = (state==HANDSHAKE) && (fifo_count < FIFO_DEPTH), decoded from registers only. Transfer occurs when `master_ready`=1 and `slave_valid`=1 on the same edge; go to RECEIVE and clear bit index.
- RECEIVE: sample `rx_data` on DATA_LEN consecutive edges. Bit i is stored at [i] (MSB_FIRST=0) or [DATA_LEN-1-i] (MSB_FIRST=1). On the edge of the last bit, push the assembled word (including that bit) into the FIFO. Then:
  - if words_left==0: pulse `rx_done` and go to IDLE;
  - else: decrement words_left and go to HANDSHAKE.
- Word count per burst is `burst_num`+1; `burst_num`=0 gives a single word.
- Timeout (TIMEOUT>0): wait counter clears on every HANDSHAKE entry and increments each HANDSHAKE cycle without transfer. When it reaches TIMEOUT: pulse `rx_timeout`, go to IDLE, no `rx_done`. Words already pushed stay in the FIFO.
- FIFO behaviour:
  - `out_valid` = fifo_count≠0; `out_data` = head word; pop on `out_valid`&&`out_ready`.
  - Push and pop on the same edge leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
  - Overflow cannot occur: a word is only accepted with a free slot, and at most one word is in flight. Pop while empty is ignored.
  - Full FIFO holds `master_ready` low; it is not a timeout exemption, so the wait counter keeps running.

## Timing
- Reset (async, `reset`=0): state IDLE; FIFO empty. `master_ready`, `out_valid`, `rx_done`, `rx_timeout` are 0; `out_data`=0; `fifo_count`=0; counters cleared. Reset mid-burst discards the partial word and all buffered words.
- Start: trigger seen at edge E → HANDSHAKE from E+1; `master_ready` can be high in cycle E+1.
- Transfer at edge T → bits sampled at edges T+1 … T+DATA_LEN; the word is visible on `out_data`/`out_valid` (FIFO previously empty) in the cycle after edge T+DATA_LEN.
- `rx_done`/`rx_timeout` are high exactly one cycle, the cycle after the final push or timeout edge; the state is IDLE in that cycle.
- Next-word handshake is possible at edge T+DATA_LEN+1 at the earliest.
- New trigger is accepted in the `rx_done` cycle.

## Test plan
- Reset and single word: DATA_LEN=8, MSB_FIRST=0, burst_num=0, trigger, then slave_valid and serial bits 1,0,1,0,0,0,0,1 → out_data=8'h85, out_valid rises 9 cycles after transfer, rx_done one cycle, fifo_count=1.
- MSB-first: MSB_FIRST=1, same bit stream → out_data=8'hA1.
- Burst with backpressure: FIFO_DEPTH=4, burst_num=5, out_ready=0 → master_ready drops with fifo_count=4. Release out_ready → all 6 words popped in order, and rx_done fires once after word 6.
- Timeout: TIMEOUT=10, slave_valid held 0 → rx_timeout pulses after 10 HANDSHAKE cycles, state IDLE, rx_done stays 0.
- Simultaneous push/pop: pop on the same edge as the last-bit push with fifo_count=2 → fifo_count stays 2, data order preserved.
- Reset mid-word: assert reset after bit 3 → all outputs return to reset values immediately; the next burst receives correctly.

Source files
------------

// File: rtl/master_rx_port.sv
// Master-side serial receive port: handshakes each burst word with the slave,
// deserialises it and buffers it in a small first-word-fall-through FIFO.
module master_rx_port #(
  parameter int DATA_LEN   = 8,
  parameter int BURST_W    = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_done,
  input  logic [1:0]                    instruction,
  input  logic [BURST_W-1:0]            burst_num,
  input  logic                          slave_valid,
  input  logic                          rx_data,
  output logic                          master_ready,
  output logic                          out_valid,
  output logic [DATA_LEN-1:0]           out_data,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_done,
  output logic                          rx_timeout
);

  localparam int IDX_W  = $clog2(DATA_LEN);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0]        OP_READ   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    HANDSHAKE,
    RECEIVE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BURST_W-1:0]  words_left;
  logic [IDX_W-1:0]    bit_idx;
  logic [IDX_W-1:0]    bit_pos;
  logic [DATA_LEN-1:0] rx_word;
  logic [DATA_LEN-1:0] word_next;
  logic [WAIT_W-1:0]   wait_cnt;

  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  logic start;
  logic xfer;
  logic last_bit;
  logic push;
  logic pop;
  logic timed_out;

  assign start        = (state == IDLE) && tx_done && (instruction == OP_READ);
  assign master_ready = (state == HANDSHAKE) && (count < FULL_CNT);
  assign xfer         = master_ready && slave_valid;
  assign last_bit     = (state == RECEIVE) && (bit_idx == LAST_IDX);
  assign push         = last_bit;
  assign pop          = out_valid && out_ready;
  assign timed_out    = (TIMEOUT != 0) && (state == HANDSHAKE) && !xfer &&
                        (wait_cnt == WAIT_LAST);

  // Serial bit i lands at [i] or, for MSB-first links, at [DATA_LEN-1-i].
  assign bit_pos = (MSB_FIRST != 0) ? (LAST_IDX - bit_idx) : bit_idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    word_next          = rx_word;
    word_next[bit_pos] = rx_data;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (start) state_next = HANDSHAKE;
      HANDSHAKE: begin
        if (xfer)           state_next = RECEIVE;
        else if (timed_out) state_next = IDLE;
      end
      RECEIVE:   if (last_bit) state_next = (words_left == '0) ? IDLE : HANDSHAKE;
      default:   state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is only ever written with non-blocking assignments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_left <= '0;
      bit_idx    <= '0;
      rx_word    <= '0;
      wait_cnt   <= '0;
      rx_done    <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      rx_done    <= last_bit && (words_left == '0);
      rx_timeout <= timed_out;

      if (start)
        words_left <= burst_num;
      else if (last_bit && (words_left != '0))
        words_left <= words_left - BURST_W'(1);

      if (xfer) begin
        bit_idx <= '0;
        rx_word <= '0;
      end else if (state == RECEIVE) begin
        rx_word <= word_next;
        if (!last_bit) bit_idx <= bit_idx + IDX_W'(1);
      end

      // Leaving HANDSHAKE clears the counter, so every entry starts from zero.
      if ((state != HANDSHAKE) || xfer)
        wait_cnt <= '0;
      else if ((TIMEOUT != 0) && !timed_out)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // NOTE: word storage has no reset; out_data is forced to zero while the FIFO is empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_master_rx_port.sv
// Randomised bench for master_rx_port: LSB-first and MSB-first instances share
// stimulus and are checked against a queue-based model of the burst protocol.
module tb_master_rx_port;

  localparam int DL = 8;
  localparam int BW = 12;
  localparam int FD = 4;
  localparam int TO = 10;
  localparam int CW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_done = 1'b0;
  logic [1:0]    instruction = 2'b00;
  logic [BW-1:0] burst_num = '0;
  logic          slave_valid = 1'b0;
  logic          rx_data = 1'b0;
  logic          out_ready = 1'b0;

  logic          mr_l, ov_l, done_l, to_l;
  logic [DL-1:0] od_l;
  logic [CW-1:0] fc_l;
  logic          mr_m, ov_m, done_m, to_m;
  logic [DL-1:0] od_m;
  logic [CW-1:0] fc_m;

  int total = 0;
  int bad   = 0;

  logic [DL-1:0] sb[$];
  bit hs_exp   = 1'b0;
  bit exp_done = 1'b0;
  bit exp_to   = 1'b0;
  int ready_mode   = 0;
  int stall_cycles = 0;

  always #5 clk = ~clk;

  master_rx_port #(
    .DATA_LEN(DL), .BURST_W(BW), .FIFO_DEPTH(FD), .MSB_FIRST(0), .TIMEOUT(TO)
  ) dut_l (
    .clk(clk), .reset(reset), .tx_done(tx_done), .instruction(instruction),
    .burst_num(burst_num), .slave_valid(slave_valid), .rx_data(rx_data),
    .master_ready(mr_l), .out_valid(ov_l), .out_data(od_l), .out_ready(out_ready),
    .fifo_count(fc_l), .rx_done(done_l), .rx_timeout(to_l)
  );

  master_rx_port #(
    .DATA_LEN(DL), .BURST_W(BW), .FIFO_DEPTH(FD), .MSB_FIRST(1), .TIMEOUT(TO)
  ) dut_m (
    .clk(clk), .reset(reset), .tx_done(tx_done), .instruction(instruction),
    .burst_num(burst_num), .slave_valid(slave_valid), .rx_data(rx_data),
    .master_ready(mr_m), .out_valid(ov_m), .out_data(od_m), .out_ready(out_ready),
    .fifo_count(fc_m), .rx_done(done_m), .rx_timeout(to_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard words are stored in serial order (bit i = i-th bit sent).
  function automatic logic [DL-1:0] rev(input logic [DL-1:0] x);
    logic [DL-1:0] r;
    for (int i = 0; i < DL; i++) r[i] = x[DL-1-i];
    return r;
  endfunction

  task automatic check_reset_values();
    check("rst_master_ready_l", mr_l, 0);
    check("rst_out_valid_l", ov_l, 0);
    check("rst_out_data_l", od_l, 0);
    check("rst_fifo_count_l", fc_l, 0);
    check("rst_rx_done_l", done_l, 0);
    check("rst_rx_timeout_l", to_l, 0);
    check("rst_master_ready_m", mr_m, 0);
    check("rst_out_valid_m", ov_m, 0);
    check("rst_out_data_m", od_m, 0);
    check("rst_fifo_count_m", fc_m, 0);
  endtask

  // One clock cycle: check every output against the model, then advance.
  task automatic tick(input bit lb);
    logic [DL-1:0] head;
    bit pop_now;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = 1'($urandom_range(0, 1));
      3:       out_ready = (stall_cycles >= 4);
      default: out_ready = lb;
    endcase
    check("master_ready_l", mr_l, hs_exp && (sb.size() < FD));
    check("master_ready_m", mr_m, hs_exp && (sb.size() < FD));
    check("out_valid_l", ov_l, sb.size() != 0);
    check("out_valid_m", ov_m, sb.size() != 0);
    check("fifo_count_l", fc_l, sb.size());
    check("fifo_count_m", fc_m, sb.size());
    check("rx_done_l", done_l, exp_done);
    check("rx_done_m", done_m, exp_done);
    check("rx_timeout_l", to_l, exp_to);
    check("rx_timeout_m", to_m, exp_to);
    if (sb.size() != 0) begin
      head = sb[0];
      check("out_data_l", od_l, head);
      check("out_data_m", od_m, rev(head));
    end
    if (hs_exp && (mr_l === 1'b0) && (fc_l == CW'(FD))) stall_cycles++;
    pop_now = out_ready && (sb.size() != 0);
    @(posedge clk);
    #1;
    if (pop_now) void'(sb.pop_front());
    exp_done = 1'b0;
    exp_to   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tx_done     = 1'($urandom);
      instruction = 2'($urandom_range(0, 2));
      burst_num   = BW'($urandom);
      slave_valid = 1'($urandom);
      rx_data     = 1'($urandom);
      tick(1'b0);
    end
    tx_done = 1'b0;
  endtask

  task automatic reset_mid();
    #2 reset = 1'b0;
    #1;
    check_reset_values();
    sb.delete();
    hs_exp = 1'b0;
    exp_done = 1'b0;
    exp_to = 1'b0;
    tx_done = 1'b0;
    slave_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
  endtask

  task automatic burst(input int nwords, input int max_lat, input int stall_word,
                       input int pop_word, input int rst_bit, input bit fixed_en,
                       input logic [DL-1:0] fixed_word);
    logic [DL-1:0] bits;
    int waited;
    int gap;
    bit xfer;
    tx_done     = 1'b1;
    instruction = 2'b11;
    burst_num   = BW'(nwords - 1);
    slave_valid = 1'b0;
    tick(1'b0);
    hs_exp = 1'b1;
    for (int w = 0; w < nwords; w++) begin
      bits   = fixed_en ? fixed_word : DL'($urandom);
      gap    = $urandom_range(0, max_lat);
      waited = 0;
      xfer   = 1'b0;
      while (!xfer) begin
        slave_valid = (w != stall_word) && (waited >= gap);
        rx_data     = 1'($urandom);
        tx_done     = 1'($urandom);
        instruction = 2'($urandom);
        burst_num   = BW'($urandom);
        xfer = slave_valid && (sb.size() < FD);
        tick(1'b0);
        if (!xfer) begin
          waited++;
          if (waited == TO) begin
            hs_exp = 1'b0;
            exp_to = 1'b1;
            tx_done = 1'b0;
            slave_valid = 1'b0;
            return;
          end
        end
      end
      hs_exp = 1'b0;
      for (int b = 0; b < DL; b++) begin
        rx_data     = bits[b];
        slave_valid = 1'($urandom);
        tx_done     = 1'($urandom);
        instruction = 2'($urandom);
        tick((b == DL - 1) && (w == pop_word));
        if ((b == rst_bit) && (w == nwords - 1)) begin
          reset_mid();
          return;
        end
      end
      sb.push_back(bits);
      if (w == nwords - 1) exp_done = 1'b1;
      else                 hs_exp = 1'b1;
    end
    tx_done = 1'b0;
    slave_valid = 1'b0;
  endtask

  initial begin
    int n;
    int stall;
    repeat (2) @(posedge clk);
    #3;
    check_reset_values();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single word, fixed pattern 1,0,1,0,0,0,0,1.
    ready_mode = 0;
    idle(2);
    burst(1, 0, -1, -1, -1, 1'b1, 8'h85);
    check("single_lsb_data", od_l, 8'h85);
    check("single_msb_data", od_m, 8'hA1);
    check("single_count", fc_l, 1);
    ready_mode = 1;
    idle(3);

    // Six-word burst against a stalled consumer, released once the FIFO is full.
    ready_mode = 3;
    stall_cycles = 0;
    burst(6, 2, -1, -1, -1, 1'b0, '0);
    check("bp_stall_seen", stall_cycles >= 4, 1);
    idle(8);

    // Timeouts: silent slave on the first word, then on the second word.
    ready_mode = 1;
    burst(1, 0, 0, -1, -1, 1'b0, '0);
    idle(3);
    ready_mode = 0;
    burst(3, 1, 1, -1, -1, 1'b0, '0);
    check("timeout_keeps_word", fc_l, 1);
    ready_mode = 1;
    idle(4);

    // Pop on the same edge as the last-bit push with two words buffered.
    ready_mode = 4;
    burst(3, 1, -1, 2, -1, 1'b0, '0);
    check("pushpop_count", fc_l, 2);
    ready_mode = 1;
    idle(6);

    // Reset after bit 3 of the second word, then a clean burst.
    ready_mode = 0;
    burst(2, 0, -1, -1, 3, 1'b0, '0);
    ready_mode = 2;
    burst(2, 1, -1, -1, -1, 1'b0, '0);
    ready_mode = 1;
    idle(6);

    // Random bursts, often back to back.
    for (int k = 0; k < 40; k++) begin
      ready_mode = 2;
      n = $urandom_range(1, 6);
      stall = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      burst(n, $urandom_range(0, 3), stall, -1, -1, 1'b0, '0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    ready_mode = 1;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
